// File: rtl/modexp_datapath.sv
// Datapath for modular exponentiation (result = base^exp mod m), driven by the sequencing FSM strobes.
// Optional MODEXP_ERR_EN adds a sticky mod_err flag for a zero modulus.
module modexp_datapath #(
  parameter int W = 8,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         initialize,
  input  logic         en_multiply,
  input  logic         en_modulo,
  input  logic         done,
  input  logic [W-1:0] base_in,
  input  logic [E-1:0] exp_in,
  input  logic [W-1:0] mod_in,
  output logic         is_multiplication_done,
  output logic [W-1:0] result,
  output logic         result_valid
`ifdef MODEXP_ERR_EN
  ,
  output logic         mod_err
`endif
);

  localparam int PW = 2 * W;

  logic [W-1:0]  base_q, base_d;
  logic [W-1:0]  mod_q, mod_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [PW-1:0] product_q, product_d;
  logic [E-1:0]  count_q, count_d;
  logic [W-1:0]  result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          err_active;

`ifdef MODEXP_ERR_EN
  logic mod_err_q, mod_err_d;
  assign err_active = mod_err_q;
  assign mod_err    = mod_err_q;
`else
  assign err_active = 1'b0;
`endif

  assign is_multiplication_done = (count_q == '0);
  assign result                 = result_q;
  assign result_valid           = result_valid_q;

  // Strobes are mutually exclusive in practice; the if-chain fixes the priority anyway.
  always_comb begin
    base_d         = base_q;
    mod_d          = mod_q;
    acc_d          = acc_q;
    product_d      = product_q;
    count_d        = count_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
`ifdef MODEXP_ERR_EN
    mod_err_d      = mod_err_q;
`endif
    if (initialize) begin
      base_d    = base_in;
      mod_d     = mod_in;
      count_d   = exp_in;
      product_d = '0;
      acc_d     = (mod_in == W'(1)) ? '0 : W'(1);
`ifdef MODEXP_ERR_EN
      mod_err_d = (mod_in == '0);
`endif
    end else if (en_multiply) begin
      if (count_q != '0) begin
        product_d = PW'(acc_q) * PW'(base_q);
        count_d   = count_q - E'(1);
      end
    end else if (en_modulo) begin
      if (!err_active) begin
        // Zero modulus means "no reduction": keep the low W bits of the product.
        if (mod_q != '0) begin
          acc_d = W'(product_q % PW'(mod_q));
        end else begin
          acc_d = product_q[W-1:0];
        end
      end
    end else if (done) begin
      result_d       = err_active ? '0 : acc_q;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q         <= '0;
      mod_q          <= '0;
      acc_q          <= '0;
      product_q      <= '0;
      count_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
`ifdef MODEXP_ERR_EN
      mod_err_q      <= 1'b0;
`endif
    end else begin
      base_q         <= base_d;
      mod_q          <= mod_d;
      acc_q          <= acc_d;
      product_q      <= product_d;
      count_q        <= count_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
`ifdef MODEXP_ERR_EN
      mod_err_q      <= mod_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_modexp_datapath.sv
// Directed bench for modexp_datapath: plays the FSM role and checks results against hand-computed values.
module tb_modexp_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       initialize = 1'b0;
  logic       en_multiply = 1'b0;
  logic       en_modulo = 1'b0;
  logic       done = 1'b0;
  logic [7:0] base_in = '0;
  logic [7:0] exp_in = '0;
  logic [7:0] mod_in = '0;
  logic       is_multiplication_done;
  logic [7:0] result;
  logic       result_valid;
`ifdef MODEXP_ERR_EN
  logic       mod_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modexp_datapath #(.W(8), .E(8)) dut (
    .clk(clk),
    .rst(rst),
    .initialize(initialize),
    .en_multiply(en_multiply),
    .en_modulo(en_modulo),
    .done(done),
    .base_in(base_in),
    .exp_in(exp_in),
    .mod_in(mod_in),
    .is_multiplication_done(is_multiplication_done),
    .result(result),
    .result_valid(result_valid)
`ifdef MODEXP_ERR_EN
    ,
    .mod_err(mod_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m);
    base_in = b;
    exp_in = e;
    mod_in = m;
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    base_in = 8'hA5;
    exp_in = 8'h5A;
    mod_in = 8'h3C;
  endtask

  task automatic run(input string tag, input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                     input logic [7:0] exp_res, input logic [7:0] prev_res, input bit extra);
    int iters;
    do_init(b, e, m);
    check({tag, "_imd_after_init"}, 32'(is_multiplication_done), 32'(e == 8'd0));
    check({tag, "_result_held_by_init"}, 32'(result), 32'(prev_res));
    iters = 0;
    while (!is_multiplication_done && iters < 300) begin
      en_multiply = 1'b1;
      tick();
      en_multiply = 1'b0;
      en_modulo = 1'b1;
      tick();
      en_modulo = 1'b0;
      iters++;
    end
    check({tag, "_iterations"}, 32'(iters), 32'(e));
    if (extra) begin
      // Multiply at count 0 must not change state or wrap the counter.
      en_multiply = 1'b1;
      tick();
      en_multiply = 1'b0;
      en_modulo = 1'b1;
      tick();
      en_modulo = 1'b0;
      check({tag, "_imd_no_wrap"}, 32'(is_multiplication_done), 32'd1);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check({tag, "_valid_pulse"}, 32'(result_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    tick();
    check({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(exp_res));
    $display("txn %s: base=%0d exp=%0d mod=%0d result=%0d expected=%0d iters=%0d",
             tag, b, e, m, result, exp_res, iters);
  endtask

  initial begin
    tick();
    tick();
    check("reset_result", 32'(result), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_imd", 32'(is_multiplication_done), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run("c1", 8'd3, 8'd4, 8'd7, 8'd4, 8'd0, 1'b0);
    run("c2", 8'd2, 8'd10, 8'd250, 8'd24, 8'd4, 1'b1);
    run("c3a", 8'd5, 8'd0, 8'd7, 8'd1, 8'd24, 1'b0);
    run("c3b", 8'd5, 8'd0, 8'd1, 8'd0, 8'd1, 1'b0);
    run("c4", 8'd255, 8'd2, 8'd251, 8'd16, 8'd0, 1'b0);

    // Asynchronous reset in the middle of a modulo step of case 2.
    do_init(8'd2, 8'd10, 8'd250);
    for (int i = 0; i < 3; i++) begin
      en_multiply = 1'b1;
      tick();
      en_multiply = 1'b0;
      en_modulo = 1'b1;
      tick();
      en_modulo = 1'b0;
    end
    en_multiply = 1'b1;
    tick();
    en_multiply = 1'b0;
    en_modulo = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("c5_rst_result", 32'(result), 32'd0);
    check("c5_rst_valid", 32'(result_valid), 32'd0);
    check("c5_rst_imd", 32'(is_multiplication_done), 32'd1);
    tick();
    en_modulo = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("c5_idle_valid", 32'(result_valid), 32'd0);
    end
    $display("txn c5: reset mid-modulo result=%0d valid=%0d", result, result_valid);
    run("c5_rerun", 8'd3, 8'd4, 8'd7, 8'd4, 8'd0, 1'b0);

`ifdef MODEXP_ERR_EN
    run("c6", 8'd3, 8'd2, 8'd0, 8'd0, 8'd4, 1'b0);
    check("c6_mod_err_set", 32'(mod_err), 32'd1);
    do_init(8'd3, 8'd1, 8'd7);
    check("c6_mod_err_clear", 32'(mod_err), 32'd0);
`else
    run("c6", 8'd3, 8'd2, 8'd0, 8'd9, 8'd4, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
